// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared widths and read-slot state encoding for the RAM port arbiter
package ram_ctrl_pkg;
  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, INFLIGHT, RSP_HOLD} slot_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way round-robin arbiter; clk/rst, req[1:0] in, grant[1:0] out, accept advances the pointer
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);
  // last = index of the requester granted most recently; resets to 1 so requester 0 wins first
  logic last;
  always_comb grant = {req[1] & (~req[0] | ~last), req[0] & (~req[1] | last)};
  always_ff @(posedge clk)
    if (rst) last <= 1'b1;
    else if (accept) last <= grant[1];
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one RAM port between two requesters, one outstanding read each
//   req_*  : per-requester request channel (valid/ready/we/addr/wdata)
//   rsp_*  : per-requester read response channel (valid/ready/rdata)
//   ram_*  : single RAM port, ram_dout registered one cycle after ram_en
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_we,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  output logic [1:0]             rsp_valid,
  input  logic [1:0]             rsp_ready,
  output logic [1:0][DATA_W-1:0] rsp_rdata,
  output logic                   ram_en,
  output logic                   ram_we,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [DATA_W-1:0]      ram_din,
  input  logic [DATA_W-1:0]      ram_dout
);
  logic [1:0] elig, grant, rd_grant;
  logic       xfer, gi;

  rr_arb2 u_arb (.clk(clk), .rst(rst), .req(elig), .accept(xfer), .grant(grant));

  assign req_ready = grant;
  assign xfer      = |grant;
  assign gi        = grant[1];
  assign ram_en    = xfer;
  assign ram_we    = xfer & req_we[gi];
  assign ram_addr  = xfer ? req_addr[gi] : '0;
  assign ram_din   = xfer ? req_wdata[gi] : '0;

  for (genvar i = 0; i < 2; i++) begin : g_slot
    slot_t             state;
    logic [DATA_W-1:0] rdata;
    logic              free;
    // A held response being popped this cycle frees the slot for a back-to-back read
    assign free        = (state == IDLE) | ((state == RSP_HOLD) & rsp_ready[i]);
    assign elig[i]     = ~rst & req_valid[i] & (req_we[i] | free);
    assign rd_grant[i] = grant[i] & ~req_we[i];
    assign rsp_valid[i] = ~rst & (state == RSP_HOLD);
    assign rsp_rdata[i] = rst ? '0 : rdata;
    always_ff @(posedge clk)
      if (rst) begin
        state <= IDLE;
        rdata <= '0;
      end else begin
        unique case (state)
          IDLE:     if (rd_grant[i]) state <= INFLIGHT;
          INFLIGHT: begin
            state <= RSP_HOLD;
            rdata <= ram_dout;
          end
          RSP_HOLD: if (rsp_ready[i]) state <= rd_grant[i] ? INFLIGHT : IDLE;
          default:  state <= IDLE;
        endcase
      end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed and random checks of ram_port_arbiter against a transaction-level model
module tb_ram_port_arbiter;
  localparam int AW = 3;
  localparam int DW = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [1:0][AW-1:0]  req_addr;
  logic [1:0][DW-1:0]  req_wdata, rsp_rdata;
  logic                ram_en, ram_we;
  logic [AW-1:0]       ram_addr;
  logic [DW-1:0]       ram_din, ram_dout;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // External RAM port: read-first, registered output
  logic [DW-1:0] ram [8];
  always @(posedge clk)
    if (ram_en) begin
      ram_dout <= ram[ram_addr];
      if (ram_we) ram[ram_addr] <= ram_din;
    end

  int passed = 0;
  int total  = 0;

  // Transaction-level model: memory image, outstanding read per requester, last winner
  logic [DW-1:0] ref_mem [8];
  bit            busy [2];
  int            ready_at [2];
  logic [DW-1:0] exp_data [2];
  int            last = 1;
  int            cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
  endtask

  task automatic step(input bit r, input logic [1:0] v, input logic [1:0] we,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [1:0] rr);
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    logic [1:0] hold, elig;
    int g;
    a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
    @(negedge clk);
    rst = r; req_valid = v; req_we = we; rsp_ready = rr;
    req_addr[0] = a0; req_addr[1] = a1; req_wdata[0] = d0; req_wdata[1] = d1;
    #1;
    for (int i = 0; i < 2; i++) begin
      hold[i] = !r && busy[i] && cyc >= ready_at[i];
      elig[i] = !r && v[i] && (we[i] || !busy[i] || (hold[i] && rr[i]));
    end
    g = (elig == 2'b11) ? 1 - last : elig[0] ? 0 : elig[1] ? 1 : -1;
    chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    chk("ram_en", 32'(ram_en), 32'(g >= 0));
    chk("ram_we", 32'(ram_we), 32'(g >= 0 && we[g]));
    chk("ram_addr", 32'(ram_addr), (g < 0) ? 32'd0 : 32'(a[g]));
    chk("ram_din", 32'(ram_din), (g < 0) ? 32'd0 : 32'(d[g]));
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rsp_valid%0d", i), 32'(rsp_valid[i]), 32'(hold[i]));
      if (r || hold[i]) chk($sformatf("rsp_rdata%0d", i), 32'(rsp_rdata[i]), r ? 32'd0 : 32'(exp_data[i]));
    end
    @(posedge clk);
    if (r) begin
      busy[0] = 0; busy[1] = 0; last = 1;
    end else begin
      for (int i = 0; i < 2; i++) if (hold[i] && rr[i]) busy[i] = 0;
      if (g >= 0) begin
        last = g;
        if (we[g]) ref_mem[a[g]] = d[g];
        else begin
          busy[g] = 1; ready_at[g] = cyc + 2; exp_data[g] = ref_mem[a[g]];
        end
      end
    end
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin ram[i] = '0; ref_mem[i] = '0; end
    ram_dout = '0;
    rst = 1'b1; req_valid = '0; req_we = '0; rsp_ready = '0; req_addr = '0; req_wdata = '0;
    // reset with busy inputs: everything must stay quiet
    step(1, 2'b11, 2'b01, 3, 4, 8'h11, 8'h22, 2'b11);
    step(1, 2'b11, 2'b10, 1, 2, 8'h33, 8'h44, 2'b11);
    // single write, then read back with a 2-cycle latency
    step(0, 2'b01, 2'b01, 3, 0, 8'hA5, 0, 2'b11);
    step(0, 2'b01, 2'b00, 3, 0, 0, 0, 2'b11);
    repeat (3) step(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b11);
    // contention right after reset: alternating grants starting at 0
    step(1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b11);
    repeat (8) step(0, 2'b11, 2'b00, 3, 6, 0, 0, 2'b11);
    repeat (3) step(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b11);
    // backpressure on requester 1
    step(0, 2'b10, 2'b10, 0, 5, 0, 8'h3C, 2'b11);
    step(0, 2'b10, 2'b00, 0, 5, 0, 0, 2'b01);
    repeat (2) step(0, 2'b10, 2'b00, 0, 5, 0, 0, 2'b01);
    step(0, 2'b10, 2'b10, 0, 7, 0, 8'h77, 2'b01);
    step(0, 2'b11, 2'b00, 3, 5, 0, 0, 2'b01);
    step(0, 2'b10, 2'b00, 0, 7, 0, 0, 2'b01);
    // pop and issue in the same cycle
    step(0, 2'b10, 2'b00, 0, 7, 0, 0, 2'b11);
    repeat (4) step(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b11);
    // cross-requester write then read of the same address
    step(0, 2'b01, 2'b01, 2, 0, 8'h5A, 0, 2'b11);
    step(0, 2'b10, 2'b00, 0, 2, 0, 0, 2'b11);
    repeat (3) step(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b11);
    // reset in the cycle after a read transfer, then contention
    step(0, 2'b01, 2'b00, 3, 0, 0, 0, 2'b11);
    step(1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b11);
    repeat (3) step(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b11);
    repeat (4) step(0, 2'b11, 2'b00, 1, 2, 0, 0, 2'b11);
    // random traffic with occasional reset
    repeat (600)
      step($urandom_range(0, 59) == 0, 2'($urandom), 2'($urandom), 3'($urandom), 3'($urandom),
           8'($urandom), 8'($urandom), 2'($urandom_range(0, 3) != 0 ? 3 : $urandom));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 3, RAM address width; DATA_W, default 8, RAM data width.
REQ-002 clk  input  1  single clock; all logic SHALL be on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req_valid[1:0]  input  2  per-requester access request.
REQ-005 req_ready[1:0]  output  2  per-requester grant; a transfer occurs on valid&&ready.
REQ-006 req_we[1:0]  input  2  per-requester write enable (1=write, 0=read).
REQ-007 req_addr[1:0]  input  2xADDR_W  per-requester address.
REQ-008 req_wdata[1:0]  input  2xDATA_W  per-requester write data.
REQ-009 rsp_valid[1:0]  output  2  read data available, per requester.
REQ-010 rsp_ready[1:0]  input  2  requester accepts read data.
REQ-011 rsp_rdata[1:0]  output  2xDATA_W  read data, per requester.
REQ-012 ram_en, ram_we  output  1 each  RAM port enable and write enable.
REQ-013 ram_addr  output  ADDR_W  RAM port address.
REQ-014 ram_din  output  DATA_W  RAM write data.
REQ-015 ram_dout  input  DATA_W  RAM registered read data, valid one cycle after an enabled access.

Function
REQ-016 Requester i SHALL be eligible when req_valid[i]=1 and either req_we[i]=1 or its read slot is free.
REQ-017 A read slot SHALL be free when the slot is IDLE, or when it is RSP_HOLD with rsp_ready[i]=1 in the same cycle.
REQ-018 At most one req_ready bit SHALL be high per cycle, and only for an eligible requester; req_ready SHALL be combinational from eligibility and the round-robin pointer.
REQ-019 Round-robin: when both requesters are eligible, the grant SHALL go to the requester not granted last; when only one is eligible, it SHALL be granted every cycle with no bubble.
REQ-020 The last-granted pointer SHALL update only on a transfer.
REQ-021 In a transfer cycle N, ram_en SHALL be 1, and ram_we/ram_addr/ram_din SHALL equal the granted requester's req_we/req_addr/req_wdata, combinationally.
REQ-022 With no transfer, ram_en and ram_we SHALL be 0.
REQ-023 Each requester SHALL have a read-slot FSM with states IDLE -> INFLIGHT (read transfer in cycle N) -> RSP_HOLD (ram_dout captured at end of cycle N+1) -> IDLE (on rsp handshake).
REQ-024 If a new read is granted in the same cycle as the rsp handshake, RSP_HOLD SHALL go directly to INFLIGHT.
REQ-025 rsp_valid[i] SHALL be 1 exactly when slot i is RSP_HOLD; read latency SHALL be 2 cycles minimum (transfer in N, rsp_valid from N+2).
REQ-026 rsp_rdata[i] SHALL be held stable while rsp_valid[i]=1 and rsp_ready[i]=0.
REQ-027 Each requester SHALL have at most one outstanding read; no read-data reordering SHALL be possible.
REQ-028 Writes SHALL produce no response; the read-first ram_dout after a write SHALL be ignored.
REQ-029 Writes by a requester SHALL be grantable while its own read is INFLIGHT or RSP_HOLD.
REQ-030 A read from one requester issued the cycle after another requester's write to the same address SHALL return the new data, since the RAM port serializes accesses.

Reset
REQ-031 While rst=1, the following SHALL all be 0: req_ready, rsp_valid, ram_en, ram_we.
REQ-032 While rst=1, ram_addr, ram_din and rsp_rdata SHALL be 0.
REQ-033 On reset, both slots SHALL go to IDLE and the pointer SHALL be set so requester 0 wins the first contention.
REQ-034 Reset asserted mid-read SHALL discard the INFLIGHT or RSP_HOLD data; no rsp_valid SHALL appear after reset for a pre-reset read.

Structure
REQ-035 Package ram_ctrl_pkg SHALL hold the ADDR_W/DATA_W default constants and the slot-state enum (IDLE, INFLIGHT, RSP_HOLD).
REQ-036 Sub-module rr_arb2 (2-way round-robin arbiter with pointer update on an accept input) SHALL be instantiated once.
REQ-037 The RAM SHALL be external to this block; ram_* SHALL connect to one port of the team's dual-port RAM.

Verification
REQ-038 Reset then single write: req0 write addr=3 data=0xA5 -> req_ready[0]=1 in same cycle, ram_en=1, ram_we=1, ram_addr=3, ram_din=0xA5; no rsp_valid.
REQ-039 Read back: req0 read addr=3 in cycle N with rsp_ready=1 -> rsp_valid[0]=1 at N+2, rsp_rdata[0]=0xA5, for exactly one cycle.
REQ-040 Contention: both requesters continuously valid (reads, rsp_ready=1) -> grants alternate 0,1,0,1, starting with 0 after reset.
REQ-041 Backpressure: req1 reads addr=5 (data 0x3C) with rsp_ready[1]=0 for 5 cycles -> rsp_valid[1] and rsp_rdata[1]=0x3C held stable; second req1 read not granted; req1 writes still granted; req0 unaffected.
REQ-042 Same-cycle pop and issue: rsp_ready[1]=1 while req1 presents a new read -> grant in same cycle, next rsp_valid[1] two cycles later with the new data.
REQ-043 Reset mid-operation: rst asserted in cycle N+1 of a read -> no rsp_valid after reset deasserts; the first post-reset contention is granted to requester 0.
